l2_mesi_cache_ctrl: RTL and testbench

// - Tag/state controller for a set-associative, write-back, MESI-coherent L2 (no data array).
// - Processes one trace command at a time: L1 read/write, snooped bus ops, clear.
// - Issues bus transactions and returns snoop responses; keeps per-way true-LRU counters.

---
 rtl/l2_mesi_cache_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_l2_mesi_cache_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_mesi_cache_ctrl.sv
// l2_mesi_cache_ctrl: tag/state controller for a set-associative, write-back, MESI L2 (no data array).
// Optional build macro L1_INVAL_EN enables L1 back-invalidate strobes when a line leaves the L2.
module l2_mesi_cache_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6,
  parameter int INDEX_W  = 4,
  parameter int WAYS     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [1:0]        snoop_in,
  output logic              done,
  output logic              hit,
  output logic [1:0]        snoop_resp,
  output logic              bus_valid,
  output logic [2:0]        bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              l1_inval_valid,
  output logic [ADDR_W-1:0] l1_inval_addr,
  output logic [15:0]       evict_count
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int SETS  = 1 << INDEX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_E = 2'd2, ST_M = 2'd3;
  localparam logic [2:0] OP_NONE = 3'd0, OP_READ = 3'd1, OP_WRITE = 3'd2, OP_INV = 3'd3, OP_RFO = 3'd4;
  localparam logic [WAY_W-1:0] LRU_MAX = WAY_W'(WAYS - 1);

  typedef enum logic [2:0] {IDLE, LOOK, WB, BUS, UPD} fsm_t;

  logic [1:0]       st_mem  [SETS][WAYS];
  logic [WAY_W-1:0] lru_mem [SETS][WAYS];
  logic [TAG_W-1:0] tag_mem [SETS][WAYS];

  fsm_t               fsm_reg;
  logic [3:0]         cmd_reg;
  logic [INDEX_W-1:0] set_reg;
  logic [TAG_W-1:0]   tag_reg;
  logic [WAY_W-1:0]   way_reg;
  logic               hit_reg;
  logic               fill_reg;
  logic               access_reg;
  logic [1:0]         old_st_reg;
  logic [1:0]         new_st_reg;
  logic [1:0]         resp_reg;

  logic unused_offset;
  assign unused_offset = ^cmd_addr[OFFSET_W-1:0];

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] t, input logic [INDEX_W-1:0] s);
    return {t, s, {OFFSET_W{1'b0}}};
  endfunction

  logic [WAYS-1:0] match_vec, free_vec, oldest_vec;
  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    assign match_vec[gi]  = (st_mem[set_reg][gi] != ST_I) && (tag_mem[set_reg][gi] == tag_reg);
    assign free_vec[gi]   = (st_mem[set_reg][gi] == ST_I);
    assign oldest_vec[gi] = (lru_mem[set_reg][gi] == LRU_MAX);
  end

  logic             lk_hit;
  logic [WAY_W-1:0] hit_way, vic_way, sel_way;
  logic [1:0]       sel_st;
  logic             is_read, is_snoop;

  // Downward scans so the lowest matching index wins; a free way overrides the LRU victim.
  always_comb begin
    lk_hit  = 1'b0;
    hit_way = '0;
    vic_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (oldest_vec[w]) vic_way = WAY_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (free_vec[w]) vic_way = WAY_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match_vec[w]) begin
        lk_hit  = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    sel_way  = lk_hit ? hit_way : vic_way;
    sel_st   = st_mem[set_reg][sel_way];
    is_read  = (cmd_reg == 4'd0) || (cmd_reg == 4'd2);
    is_snoop = (cmd_reg >= 4'd3) && (cmd_reg <= 4'd6);
  end

  always_ff @(posedge clk) begin
    if (fsm_reg == UPD && fill_reg) tag_mem[set_reg][way_reg] <= tag_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg     <= IDLE;
      cmd_ready   <= 1'b1;
      done        <= 1'b0;
      hit         <= 1'b0;
      snoop_resp  <= 2'b00;
      bus_valid   <= 1'b0;
      bus_op      <= OP_NONE;
      bus_addr    <= '0;
      evict_count <= '0;
      cmd_reg     <= '0;
      set_reg     <= '0;
      tag_reg     <= '0;
      way_reg     <= '0;
      hit_reg     <= 1'b0;
      fill_reg    <= 1'b0;
      access_reg  <= 1'b0;
      old_st_reg  <= ST_I;
      new_st_reg  <= ST_I;
      resp_reg    <= 2'b00;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          st_mem[s][w]  <= ST_I;
          lru_mem[s][w] <= '0;
        end
      end
`ifdef L1_INVAL_EN
      l1_inval_valid <= 1'b0;
      l1_inval_addr  <= '0;
`endif
    end else begin
      done       <= 1'b0;
      hit        <= 1'b0;
      snoop_resp <= 2'b00;
      bus_valid  <= 1'b0;
      bus_op     <= OP_NONE;
      bus_addr   <= '0;
`ifdef L1_INVAL_EN
      l1_inval_valid <= 1'b0;
      l1_inval_addr  <= '0;
`endif
      case (fsm_reg)
        IDLE: begin
          if (cmd_valid) begin
            cmd_reg   <= cmd;
            set_reg   <= cmd_addr[OFFSET_W +: INDEX_W];
            tag_reg   <= cmd_addr[ADDR_W-1 -: TAG_W];
            cmd_ready <= 1'b0;
            fsm_reg   <= LOOK;
          end
        end
        LOOK: begin
          hit_reg    <= lk_hit;
          way_reg    <= sel_way;
          old_st_reg <= sel_st;
          new_st_reg <= sel_st;
          fill_reg   <= 1'b0;
          access_reg <= 1'b0;
          resp_reg   <= 2'b00;
          fsm_reg    <= UPD;
          if (lk_hit && is_snoop) resp_reg <= (sel_st == ST_M) ? 2'b10 : 2'b01;
          // Hit-path bus ops go out while in UPD; miss paths detour through WB/BUS.
          if (is_read || cmd_reg == 4'd1) begin
            if (lk_hit) begin
              access_reg <= 1'b1;
              if (cmd_reg == 4'd1) begin
                new_st_reg <= ST_M;
                if (sel_st == ST_S) begin
                  bus_valid <= 1'b1;
                  bus_op    <= OP_INV;
                  bus_addr  <= line_addr(tag_reg, set_reg);
                end
              end
            end else begin
              fill_reg <= 1'b1;
              if (cmd_reg == 4'd1) new_st_reg <= ST_M;
              bus_valid <= 1'b1;
              if (sel_st == ST_M) begin
                bus_op   <= OP_WRITE;
                bus_addr <= line_addr(tag_mem[set_reg][vic_way], set_reg);
                fsm_reg  <= WB;
              end else begin
                bus_op   <= is_read ? OP_READ : OP_RFO;
                bus_addr <= line_addr(tag_reg, set_reg);
                fsm_reg  <= BUS;
              end
            end
          end else if (lk_hit) begin
            if ((cmd_reg == 4'd4 || cmd_reg == 4'd6) && sel_st == ST_M) begin
              bus_valid <= 1'b1;
              bus_op    <= OP_WRITE;
              bus_addr  <= line_addr(tag_reg, set_reg);
            end
            if (cmd_reg == 4'd3 && sel_st == ST_S) new_st_reg <= ST_I;
            if (cmd_reg == 4'd4) new_st_reg <= ST_S;
            if (cmd_reg == 4'd6) new_st_reg <= ST_I;
          end
        end
        WB: begin
          bus_valid <= 1'b1;
          bus_op    <= (cmd_reg == 4'd1) ? OP_RFO : OP_READ;
          bus_addr  <= line_addr(tag_reg, set_reg);
          fsm_reg   <= BUS;
        end
        BUS: begin
          if (cmd_reg != 4'd1) new_st_reg <= (snoop_in == 2'b00) ? ST_E : ST_S;
          fsm_reg <= UPD;
        end
        UPD: begin
          done       <= 1'b1;
          hit        <= hit_reg;
          snoop_resp <= resp_reg;
          cmd_ready  <= 1'b1;
          fsm_reg    <= IDLE;
          if (cmd_reg == 4'd8) begin
            for (int s = 0; s < SETS; s++) begin
              for (int w = 0; w < WAYS; w++) begin
                st_mem[s][w]  <= ST_I;
                lru_mem[s][w] <= '0;
              end
            end
          end else if (fill_reg) begin
            for (int w = 0; w < WAYS; w++) begin
              if (WAY_W'(w) != way_reg && st_mem[set_reg][w] != ST_I && lru_mem[set_reg][w] < LRU_MAX)
                lru_mem[set_reg][w] <= lru_mem[set_reg][w] + 1'b1;
            end
            lru_mem[set_reg][way_reg] <= '0;
            st_mem[set_reg][way_reg]  <= new_st_reg;
            if (old_st_reg != ST_I) begin
              if (evict_count != 16'hFFFF) evict_count <= evict_count + 16'd1;
`ifdef L1_INVAL_EN
              l1_inval_valid <= 1'b1;
              l1_inval_addr  <= line_addr(tag_mem[set_reg][way_reg], set_reg);
`endif
            end
          end else if (access_reg) begin
            for (int w = 0; w < WAYS; w++) begin
              if (st_mem[set_reg][w] != ST_I && lru_mem[set_reg][w] < lru_mem[set_reg][way_reg])
                lru_mem[set_reg][w] <= lru_mem[set_reg][w] + 1'b1;
            end
            lru_mem[set_reg][way_reg] <= '0;
            st_mem[set_reg][way_reg]  <= new_st_reg;
          end else if (hit_reg) begin
            if (new_st_reg == ST_I) begin
              for (int w = 0; w < WAYS; w++) begin
                if (st_mem[set_reg][w] != ST_I && lru_mem[set_reg][w] > lru_mem[set_reg][way_reg])
                  lru_mem[set_reg][w] <= lru_mem[set_reg][w] - 1'b1;
              end
`ifdef L1_INVAL_EN
              l1_inval_valid <= 1'b1;
              l1_inval_addr  <= line_addr(tag_reg, set_reg);
`endif
            end
            st_mem[set_reg][way_reg] <= new_st_reg;
          end
        end
        default: fsm_reg <= IDLE;
      endcase
    end
  end

`ifndef L1_INVAL_EN
  assign l1_inval_valid = 1'b0;
  assign l1_inval_addr  = '0;
`endif

endmodule

// File: tb/tb_l2_mesi_cache_ctrl.sv
// Self-checking bench for l2_mesi_cache_ctrl: directed MESI scenarios plus random traffic
// against a recency-ordered per-set line list model.
module tb_l2_mesi_cache_ctrl;
  localparam int WAYS = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd = 4'd0;
  logic [31:0] cmd_addr = 32'd0;
  logic [1:0]  snoop_in = 2'd0;
  logic        done, hit, bus_valid, l1_inval_valid;
  logic [1:0]  snoop_resp;
  logic [2:0]  bus_op;
  logic [31:0] bus_addr, l1_inval_addr;
  logic [15:0] evict_count;

  always #5 clk = ~clk;

  l2_mesi_cache_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .cmd_addr(cmd_addr), .snoop_in(snoop_in), .done(done), .hit(hit), .snoop_resp(snoop_resp),
    .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr), .l1_inval_valid(l1_inval_valid),
    .l1_inval_addr(l1_inval_addr), .evict_count(evict_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: each set is a list of valid lines, front = most recently used.
  typedef struct packed { logic [21:0] tag; logic [1:0] st; } line_t;
  localparam logic [1:0] I = 2'd0, S = 2'd1, E = 2'd2, M = 2'd3;
  line_t       sets_q [16][$];
  int unsigned m_evict;
  logic [34:0] exp_bus_q [$];
  logic        exp_hit;
  logic [1:0]  exp_resp;
  int          exp_lat;

  logic [34:0] first_bus, last_bus;
  logic        last_hit;
  logic [1:0]  last_resp;
  int          last_lat, last_nbus;

  function automatic logic [31:0] laddr(input logic [21:0] t, input logic [3:0] s);
    return {t, s, 6'd0};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 16; k++) sets_q[k].delete();
    m_evict = 0;
  endtask

  task automatic model_cmd(input logic [3:0] c, input logic [31:0] a, input logic [1:0] snp);
    logic [3:0]  s;
    logic [21:0] t;
    int          idx;
    line_t       ln;
    s = a[9:6];
    t = a[31:10];
    idx = -1;
    exp_bus_q.delete();
    exp_resp = 2'b00;
    exp_lat  = 2;
    for (int i = 0; i < sets_q[s].size(); i++) if (sets_q[s][i].tag == t) idx = i;
    exp_hit = (idx >= 0);
    if (c == 4'd8) begin
      for (int k = 0; k < 16; k++) sets_q[k].delete();
    end else if (c <= 4'd2) begin
      if (idx >= 0) begin
        ln = sets_q[s][idx];
        sets_q[s].delete(idx);
        if (c == 4'd1) begin
          if (ln.st == S) exp_bus_q.push_back({3'd3, laddr(t, s)});
          ln.st = M;
        end
        sets_q[s].push_front(ln);
      end else begin
        exp_lat = 3;
        if (sets_q[s].size() == WAYS) begin
          ln = sets_q[s].pop_back();
          m_evict++;
          if (ln.st == M) begin
            exp_bus_q.push_back({3'd2, laddr(ln.tag, s)});
            exp_lat = 4;
          end
        end
        ln.tag = t;
        if (c == 4'd1) begin
          exp_bus_q.push_back({3'd4, laddr(t, s)});
          ln.st = M;
        end else begin
          exp_bus_q.push_back({3'd1, laddr(t, s)});
          ln.st = (snp == 2'b00) ? E : S;
        end
        sets_q[s].push_front(ln);
      end
    end else if (c <= 4'd6 && idx >= 0) begin
      ln = sets_q[s][idx];
      exp_resp = (ln.st == M) ? 2'b10 : 2'b01;
      if (c == 4'd3 && ln.st == S) sets_q[s].delete(idx);
      if (c == 4'd4) begin
        if (ln.st == M) exp_bus_q.push_back({3'd2, laddr(t, s)});
        ln.st = S;
        sets_q[s][idx] = ln;
      end
      if (c == 4'd6) begin
        if (ln.st == M) exp_bus_q.push_back({3'd2, laddr(t, s)});
        sets_q[s].delete(idx);
      end
    end
  endtask

  task automatic run_cmd(input logic [3:0] c, input logic [31:0] a, input logic [1:0] snp);
    bit got_done;
    model_cmd(c, a, snp);
    @(negedge clk);
    check("cmd_ready_before", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd = c;
    cmd_addr = a;
    snoop_in = snp;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd = 4'd0;
    cmd_addr = $urandom;
    got_done = 1'b0;
    last_nbus = 0;
    first_bus = '0;
    for (int cyc = 0; cyc < 8 && !got_done; cyc++) begin
      @(negedge clk);
`ifndef L1_INVAL_EN
      check("l1_inval_idle", {31'd0, l1_inval_valid, l1_inval_addr}, 64'd0);
`endif
      if (bus_valid) begin
        if (last_nbus == 0) first_bus = {bus_op, bus_addr};
        last_bus = {bus_op, bus_addr};
        last_nbus++;
        if (exp_bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected: got op %0d addr 0x%0h expected no bus op (cmd %0d addr 0x%0h)", bus_op, bus_addr, c, a);
        end else begin
          check("bus_op_addr", {29'd0, bus_op, bus_addr}, {29'd0, exp_bus_q.pop_front()});
        end
      end else begin
        check("bus_idle", {29'd0, bus_op, bus_addr}, 64'd0);
      end
      if (done) begin
        got_done = 1'b1;
        last_hit = hit;
        last_resp = snoop_resp;
        last_lat = cyc;
        check("latency", 64'(cyc), 64'(exp_lat));
        check("hit", {63'd0, hit}, {63'd0, exp_hit});
        check("snoop_resp", {62'd0, snoop_resp}, {62'd0, exp_resp});
        check("evict_count", {48'd0, evict_count}, 64'(m_evict));
      end
    end
    if (!got_done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within 8 cycles, expected done at %0d (cmd %0d addr 0x%0h)", exp_lat, c, a);
    end
    check("bus_ops_missing", 64'(exp_bus_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  logic [3:0] cmd_pool [10] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd9};

  initial begin
    bit seen;
    model_reset();
    do_reset();
    @(negedge clk);
    check("reset_ready", {63'd0, cmd_ready}, 64'd1);
    check("reset_outs", {done, hit, snoop_resp, bus_valid, bus_op, evict_count}, 64'd0);
    check("reset_bus_addr", {32'd0, bus_addr}, 64'd0);

    run_cmd(4'd0, 32'h0000_1000, 2'b00);
    check("pin_rd_miss_bus", {29'd0, last_bus}, {29'd0, 3'd1, 32'h1000});
    check("pin_rd_miss_lat", 64'(last_lat), 64'd3);
    check("pin_rd_miss_hit", {63'd0, last_hit}, 64'd0);

    run_cmd(4'd1, 32'h0000_1000, 2'b00);
    check("pin_wr_hitE_hit", {63'd0, last_hit}, 64'd1);
    check("pin_wr_hitE_nobus", 64'(last_nbus), 64'd0);

    run_cmd(4'd4, 32'h0000_1000, 2'b00);
    check("pin_snprd_resp", {62'd0, last_resp}, 64'd2);
    check("pin_snprd_wb", {29'd0, last_bus}, {29'd0, 3'd2, 32'h1000});

    run_cmd(4'd1, 32'h0000_2000, 2'b00);
    check("pin_wr_miss_rfo", {29'd0, last_bus}, {29'd0, 3'd4, 32'h2000});
    run_cmd(4'd6, 32'h0000_2000, 2'b00);
    check("pin_snprfo_resp", {62'd0, last_resp}, 64'd2);
    check("pin_snprfo_wb", {29'd0, last_bus}, {29'd0, 3'd2, 32'h2000});
    run_cmd(4'd0, 32'h0000_2000, 2'b01);
    check("pin_after_rfo_miss", {63'd0, last_hit}, 64'd0);

    run_cmd(4'd8, 32'h0, 2'b00);
    run_cmd(4'd1, 32'h0001_0000, 2'b00);
    for (int k = 1; k <= 8; k++) run_cmd(4'd0, 32'(k) << 10, 2'($urandom_range(0, 2)));
    check("pin_fill_evict", {48'd0, evict_count}, 64'd1);
    check("pin_fill_wb", {29'd0, first_bus}, {29'd0, 3'd2, 32'h0001_0000});
    check("pin_fill_lat", 64'(last_lat), 64'd4);

    run_cmd(4'd0, 32'h0000_3040, 2'b01);
    run_cmd(4'd3, 32'h0000_3040, 2'b00);
    check("pin_snpinv_resp", {62'd0, last_resp}, 64'd1);
    run_cmd(4'd0, 32'h0000_3040, 2'b00);
    check("pin_snpinv_miss", {63'd0, last_hit}, 64'd0);

    run_cmd(4'd5, 32'h0000_2000, 2'b00);
    check("pin_snpwr_hit", {63'd0, last_hit}, 64'd1);
    run_cmd(4'd0, 32'h0000_2000, 2'b00);
    check("pin_snpwr_kept", {63'd0, last_hit}, 64'd1);

    run_cmd(4'd8, 32'h0, 2'b00);
    run_cmd(4'd0, 32'h0000_2000, 2'b00);
    check("pin_clear_miss", {63'd0, last_hit}, 64'd0);

    // Reset while the read-miss bus transaction is on the bus.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd = 4'd0;
    cmd_addr = 32'h0000_5000;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 6 && !seen; cyc++) begin
      @(negedge clk);
      if (bus_valid) seen = 1'b1;
    end
    check("rst_bus_seen", {63'd0, seen}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_bus_valid", {63'd0, bus_valid}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_ready", {63'd0, cmd_ready}, 64'd1);
    rst = 1'b0;
    model_reset();
    run_cmd(4'd0, 32'h0000_5000, 2'b00);
    check("rst_aborted_miss", {63'd0, last_hit}, 64'd0);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      logic [3:0]  c;
      a = {18'd0, 4'($urandom_range(0, 11)), 2'd0, 2'($urandom_range(0, 1)), 6'($urandom)};
      c = (n % 97 == 96) ? 4'd8 : cmd_pool[$urandom_range(0, 9)];
      run_cmd(c, a, 2'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
